edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel edge-event scheduler that shares one event output port among NUM_CH single-bit input lines. Each channel has a registered edge detector with per-channel rising and falling enables. Each channel also has a one-deep pending slot. A round-robin arbiter presents one pending event at a time on a valid/ready output. It sits between raw synchronous status lines and a single downstream consumer, such as an interrupt or logging unit.

## Interface
- NUM_CH, default 4: number of input channels, range 2..16.
- CH_W, default $clog2(NUM_CH): width of the channel index. Derived; do not override.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_sig  input  NUM_CH  monitored lines, already synchronous to clk.
- cfg_pos_en  input  NUM_CH  per-channel rising-edge enable.
- cfg_neg_en  input  NUM_CH  per-channel falling-edge enable.
- out_valid  output  1  an event is presented.
- out_ready  input  1  consumer accepts the event.
- out_ch  output  CH_W  channel index of the presented event.
- out_pol  output  1  event polarity: 1 = rising, 0 = falling.
- ovf  output  NUM_CH  sticky per-channel overflow flags.
- ovf_clr  input  1  single-cycle pulse that clears all ovf bits.

## Operation
- **Edge detection**
  - prev[i] is a register.
  - rise[i] = in_sig[i] & ~prev[i] & cfg_pos_en[i].
  - fall[i] = ~in_sig[i] & prev[i] & cfg_neg_en[i].
  - prev[i] <= in_sig[i] every cycle, including during rst, so no spurious edge occurs after reset.
- **Pending slot**
  - Each channel holds pend[i] plus pol[i].
  - On rise or fall: if the slot is free, or is being consumed this cycle, load pend=1 and pol=rise.
  - If the slot is still occupied (not consumed): drop the new event, keep the older one, and set ovf[i].
- **Output register**
  - The output is one registered slot.
  - It is free when out_valid=0, or when out_valid & out_ready is true this cycle.
  - When free and any pend is set, the grant selects the first pending channel at or after rr_ptr, scanning upward with wrap.
  - The output register then loads out_ch and out_pol, and clears that channel's pend.
  - rr_ptr <= granted index + 1, wrapping to 0 after NUM_CH-1.
- **Simultaneous events**
  - A channel whose pend is being granted may load a new edge in the same cycle. No overflow is raised in that case.
- **Hold rule**
  - While out_valid=1 and out_ready=0, out_ch and out_pol hold stable and no grant occurs.
- **Overflow flags**
  - ovf_clr clears all ovf bits.
  - If ovf_clr and an overflow on channel i occur in the same cycle, ovf[i] ends at 1 (set wins).
- **Enable changes**
  - Changing cfg_*_en affects detection only.
  - Events already pending or presented are delivered.
- **Reset** (synchronous, takes effect on the clock edge while rst=1)
  - out_valid=0, out_ch=0, out_pol=0.
  - All pend=0, ovf=0, rr_ptr=0.
  - A mid-transfer event is discarded.

## Timing
- Input level changes are sampled at posedge t, and pend is set at t.
- out_valid is asserted at t+1 at the earliest, which is 1 cycle of latency from a free state.
- With out_ready held at 1, one event is delivered per cycle (full throughput through back-to-back grants).
- An event is transferred in any cycle where out_valid & out_ready is true at posedge.
- out_valid never deasserts without a transfer, except on rst.
- Worst-case wait is NUM_CH-1 grants ahead of a channel under round-robin.

## Configuration
- **EDGE_ARB_FIXED_PRIO_EN**
  - Defined: the grant always selects the lowest-index pending channel. rr_ptr is removed (not implemented). Starvation of high indices is accepted.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- **Reset, idle, no spurious edge.** Hold in_sig=4'b1111 during rst, release with out_ready=1 → out_valid=0 for 5 cycles, ovf=0.
- **Single edge latency.** Set cfg_pos_en=4'b0001 and raise in_sig[0] just before posedge t → out_valid=1 at t+1 with out_ch=0, out_pol=1; it drops at t+2.
- **Round-robin fairness.** Enable all, drop out_ready to 0, then raise in_sig[3:0] together, then assert out_ready=1 → events are delivered as ch 0,1,2,3 on consecutive cycles. Repeat with rr_ptr=2 → order is 2,3,0,1.
- **Backpressure hold and overflow.** Hold out_ready=0 and toggle in_sig[1] rise→fall→rise with both edges enabled → the output holds the first event (ch 1, pol 1), ovf[1]=1, and one pending event remains. ovf_clr clears ovf[1] in the next cycle.
- **Grant plus new edge same cycle.** Pend[2] is granted in the same cycle as a fall on ch 2 → no ovf. The next event delivered is ch 2, pol 0.
- **Mid-operation reset.** Assert rst while out_valid=1 and 3 events are pending → the next cycle shows out_valid=0, all pend cleared, rr_ptr=0.

Source files
------------

// File: rtl/edge_event_arbiter_if.sv
// Event port bundle for edge_event_arbiter: monitored lines, edge enables,
// the valid/ready event output, overflow flags and internal visibility taps.
interface edge_event_arbiter_if #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] in_sig;
    logic [NUM_CH-1:0] cfg_pos_en;
    logic [NUM_CH-1:0] cfg_neg_en;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic              out_pol;
    logic [NUM_CH-1:0] ovf;
    logic              ovf_clr;
    logic [NUM_CH-1:0] dbg_pend;
    logic [CH_W-1:0]   dbg_rr_ptr;

    // Handshake: an event moves in any cycle where out_valid & out_ready are
    // high at posedge; while out_valid=1 and out_ready=0, out_ch/out_pol hold
    // and out_valid only drops after a transfer (or on reset).
    modport master (
        input  in_sig, cfg_pos_en, cfg_neg_en, out_ready, ovf_clr,
        output out_valid, out_ch, out_pol, ovf, dbg_pend, dbg_rr_ptr
    );

    modport slave (
        output in_sig, cfg_pos_en, cfg_neg_en, out_ready, ovf_clr,
        input  out_valid, out_ch, out_pol, ovf, dbg_pend, dbg_rr_ptr
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detectors with one-deep pending slots, shared through one
// registered valid/ready event output. Define EDGE_ARB_FIXED_PRIO_EN for fixed priority.
module edge_event_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    edge_event_arbiter_if.master  bus
);
    logic [NUM_CH-1:0] prev_q, prev_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pol_q, pol_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_pol_q, out_pol_d;
`ifndef EDGE_ARB_FIXED_PRIO_EN
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic [NUM_CH-1:0] rise, fall, evt, ovf_set, gnt_vec;
    logic              out_free, gnt_found, do_grant;
    logic [CH_W-1:0]   gnt_idx;

    assign rise = bus.in_sig & ~prev_q & bus.cfg_pos_en;
    assign fall = ~bus.in_sig & prev_q & bus.cfg_neg_en;
    assign evt  = rise | fall;

    assign prev_d   = bus.in_sig;
    assign out_free = ~out_valid_q | bus.out_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
`ifdef EDGE_ARB_FIXED_PRIO_EN
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(k);
            end
        end
`else
        // Scan upward from rr_ptr with wrap; first pending channel wins.
        for (int k = 0; k < NUM_CH; k++) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!gnt_found && pend_q[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(j);
            end
        end
`endif
    end

    assign do_grant = out_free & gnt_found;
    assign gnt_vec  = do_grant ? (NUM_CH'(1) << gnt_idx) : '0;

    always_comb begin
        pend_d  = pend_q;
        pol_d   = pol_q;
        ovf_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_vec[i]) pend_d[i] = 1'b0;
            // A slot being granted this cycle is free for a fresh edge.
            if (evt[i]) begin
                if (!pend_q[i] || gnt_vec[i]) begin
                    pend_d[i] = 1'b1;
                    pol_d[i]  = rise[i];
                end else begin
                    ovf_set[i] = 1'b1;
                end
            end
        end
        ovf_d = (bus.ovf_clr ? '0 : ovf_q) | ovf_set;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_pol_d   = out_pol_q;
        if (do_grant) begin
            out_valid_d = 1'b1;
            out_ch_d    = gnt_idx;
            out_pol_d   = pol_q[gnt_idx];
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifndef EDGE_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (do_grant) begin
            rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        // prev tracks the lines even in reset so release never creates an edge.
        prev_q <= prev_d;
        if (rst) begin
            pend_q      <= '0;
            pol_q       <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_pol_q   <= 1'b0;
`ifndef EDGE_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            pend_q      <= pend_d;
            pol_q       <= pol_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_pol_q   <= out_pol_d;
`ifndef EDGE_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_pol   = out_pol_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_pend  = pend_q;
`ifdef EDGE_ARB_FIXED_PRIO_EN
    assign bus.dbg_rr_ptr = '0;
`else
    assign bus.dbg_rr_ptr = rr_ptr_q;
`endif
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (NUM_CH=4): reset, latency, round-robin,
// backpressure/overflow, grant-plus-edge and mid-operation reset.
module tb_edge_event_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Expected output word: {out_valid, out_ch[1:0], out_pol}.
    logic [3:0] exp_q[$];

    edge_event_arbiter_if #(.NUM_CH(4)) bus ();
    edge_event_arbiter #(.NUM_CH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs();
        return {bus.out_valid, bus.out_ch, bus.out_pol};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_sig = 4'hF; bus.cfg_pos_en = 4'hF; bus.cfg_neg_en = 4'hF;
        bus.out_ready = 1'b1;
        tick(); tick();
        checks++; if (obs() !== 4'b0000) begin errors++; $display("FAIL reset_out: got %b expected %b", obs(), 4'b0000); end
        checks++; if (bus.ovf !== 4'h0) begin errors++; $display("FAIL reset_ovf: got %b expected %b", bus.ovf, 4'h0); end
        checks++; if (bus.dbg_pend !== 4'h0) begin errors++; $display("FAIL reset_pend: got %b expected %b", bus.dbg_pend, 4'h0); end
        checks++; if (bus.dbg_rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr: got %0d expected 0", bus.dbg_rr_ptr); end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d]: got %b expected 0", c, bus.out_valid); end
            checks++; if (bus.ovf !== 4'h0) begin errors++; $display("FAIL idle_ovf[%0d]: got %b expected 0000", c, bus.ovf); end
        end
    endtask

    task automatic test_single_latency();
        bus.cfg_pos_en = 4'b0001; bus.cfg_neg_en = 4'b0000;
        bus.in_sig = 4'h0;
        tick(); tick();
        bus.in_sig = 4'b0001;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_t: got %b expected 0", bus.out_valid); end
        checks++; if (bus.dbg_pend !== 4'b0001) begin errors++; $display("FAIL lat_pend: got %b expected 0001", bus.dbg_pend); end
        tick();
        checks++; if (obs() !== 4'b1001) begin errors++; $display("FAIL lat_t1: got %b expected %b", obs(), 4'b1001); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_t2: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        bus.cfg_pos_en = 4'hF; bus.cfg_neg_en = 4'h0;
        bus.in_sig = 4'h0; bus.out_ready = 1'b0;
        do_reset();
        bus.in_sig = 4'hF;
        tick();
        checks++; if (bus.dbg_pend !== 4'hF) begin errors++; $display("FAIL rr_pend_all: got %b expected 1111", bus.dbg_pend); end
        tick();
        checks++; if (obs() !== 4'b1001) begin errors++; $display("FAIL rr_first: got %b expected %b", obs(), 4'b1001); end
        tick();
        checks++; if (obs() !== 4'b1001) begin errors++; $display("FAIL rr_hold: got %b expected %b", obs(), 4'b1001); end
        checks++; if (bus.dbg_pend !== 4'b1110) begin errors++; $display("FAIL rr_hold_pend: got %b expected 1110", bus.dbg_pend); end
        exp_q.push_back(4'b1011); exp_q.push_back(4'b1101); exp_q.push_back(4'b1111);
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            checks++; if (obs() !== e) begin errors++; $display("FAIL rr_seq0: got %b expected %b", obs(), e); end
        end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain0: got %b expected 0", bus.out_valid); end

        // Move rr_ptr to 2 by delivering one event from channel 1.
        bus.in_sig = 4'h0; tick();
        bus.in_sig = 4'b0010; tick(); tick();
        checks++; if (obs() !== 4'b1011) begin errors++; $display("FAIL rr_ch1: got %b expected %b", obs(), 4'b1011); end
        tick();
        checks++; if (bus.dbg_rr_ptr !== 2'd2) begin errors++; $display("FAIL rr_ptr2: got %0d expected 2", bus.dbg_rr_ptr); end
        bus.out_ready = 1'b0;
        bus.in_sig = 4'h0; tick();
        bus.in_sig = 4'hF; tick(); tick();
        checks++; if (obs() !== 4'b1101) begin errors++; $display("FAIL rr_first2: got %b expected %b", obs(), 4'b1101); end
        exp_q.push_back(4'b1111); exp_q.push_back(4'b1001); exp_q.push_back(4'b1011);
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            checks++; if (obs() !== e) begin errors++; $display("FAIL rr_seq2: got %b expected %b", obs(), e); end
        end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain2: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_backpressure_ovf();
        bus.cfg_pos_en = 4'b0010; bus.cfg_neg_en = 4'b0010;
        bus.in_sig = 4'h0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        do_reset();
        bus.in_sig = 4'b0010; tick();
        checks++; if (bus.dbg_pend !== 4'b0010) begin errors++; $display("FAIL bp_rise_pend: got %b expected 0010", bus.dbg_pend); end
        bus.in_sig = 4'b0000; tick();
        checks++; if (obs() !== 4'b1011) begin errors++; $display("FAIL bp_out: got %b expected %b", obs(), 4'b1011); end
        checks++; if (bus.ovf !== 4'h0) begin errors++; $display("FAIL bp_no_ovf: got %b expected 0000", bus.ovf); end
        bus.in_sig = 4'b0010; tick();
        checks++; if (obs() !== 4'b1011) begin errors++; $display("FAIL bp_hold: got %b expected %b", obs(), 4'b1011); end
        checks++; if (bus.ovf !== 4'b0010) begin errors++; $display("FAIL bp_ovf: got %b expected 0010", bus.ovf); end
        checks++; if (bus.dbg_pend !== 4'b0010) begin errors++; $display("FAIL bp_pend: got %b expected 0010", bus.dbg_pend); end
        // Overflow coinciding with ovf_clr: the set takes priority.
        bus.in_sig = 4'b0000; bus.ovf_clr = 1'b1; tick();
        checks++; if (bus.ovf !== 4'b0010) begin errors++; $display("FAIL bp_set_wins: got %b expected 0010", bus.ovf); end
        tick();
        checks++; if (bus.ovf !== 4'b0000) begin errors++; $display("FAIL bp_clr: got %b expected 0000", bus.ovf); end
        bus.ovf_clr = 1'b0;
        bus.out_ready = 1'b1; tick();
        checks++; if (obs() !== 4'b1010) begin errors++; $display("FAIL bp_pending_fall: got %b expected %b", obs(), 4'b1010); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_grant_plus_edge();
        bus.cfg_pos_en = 4'b0100; bus.cfg_neg_en = 4'b0100;
        bus.in_sig = 4'h0; bus.out_ready = 1'b0;
        do_reset();
        bus.in_sig = 4'b0100; tick();
        bus.in_sig = 4'b0000; tick();
        checks++; if (obs() !== 4'b1101) begin errors++; $display("FAIL ge_out: got %b expected %b", obs(), 4'b1101); end
        checks++; if (bus.dbg_pend !== 4'b0100) begin errors++; $display("FAIL ge_pend: got %b expected 0100", bus.dbg_pend); end
        checks++; if (bus.ovf !== 4'h0) begin errors++; $display("FAIL ge_ovf: got %b expected 0000", bus.ovf); end
        bus.out_ready = 1'b1; tick();
        checks++; if (obs() !== 4'b1100) begin errors++; $display("FAIL ge_next: got %b expected %b", obs(), 4'b1100); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ge_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_mid_reset();
        bus.cfg_pos_en = 4'hF; bus.cfg_neg_en = 4'h0;
        bus.in_sig = 4'h0; bus.out_ready = 1'b0;
        do_reset();
        bus.in_sig = 4'hF; tick(); tick();
        checks++; if (obs() !== 4'b1001) begin errors++; $display("FAIL mr_pre_out: got %b expected %b", obs(), 4'b1001); end
        checks++; if (bus.dbg_pend !== 4'b1110) begin errors++; $display("FAIL mr_pre_pend: got %b expected 1110", bus.dbg_pend); end
        checks++; if (bus.dbg_rr_ptr !== 2'd1) begin errors++; $display("FAIL mr_pre_rr: got %0d expected 1", bus.dbg_rr_ptr); end
        rst = 1'b1; tick();
        checks++; if (obs() !== 4'b0000) begin errors++; $display("FAIL mr_out: got %b expected %b", obs(), 4'b0000); end
        checks++; if (bus.dbg_pend !== 4'h0) begin errors++; $display("FAIL mr_pend: got %b expected 0000", bus.dbg_pend); end
        checks++; if (bus.dbg_rr_ptr !== 2'd0) begin errors++; $display("FAIL mr_rr: got %0d expected 0", bus.dbg_rr_ptr); end
        rst = 1'b0; bus.out_ready = 1'b1; tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mr_after: got %b expected 0", bus.out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_sig = '0; bus.cfg_pos_en = '0; bus.cfg_neg_en = '0;
        bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        test_reset();
        test_single_latency();
        test_round_robin();
        test_backpressure_ovf();
        test_grant_plus_edge();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
